// File: rtl/card_deal_engine.sv
// N-player card dealer: draws cards from a 2**CARD_W deck without replacement and deals them in turn order.
// Optional feature: define AUTO_RESHUFFLE_EN to refill the deck automatically on a draw from an empty deck.
module card_deal_engine #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          CARD_W      = 5,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              draw_req,
  input  logic              pass_req,
  output logic              busy,
  output logic              card_valid,
  output logic [CARD_W-1:0] card_id,
  output logic [1:0]        card_color,
  output logic [CARD_W-3:0] card_number,
  output logic [PID_W-1:0]  card_player,
  output logic [PID_W-1:0]  cur_player,
  output logic [CARD_W:0]   cards_dealt,
  output logic              deck_empty,
  output logic [1:0]        fsm_state
);

  // Handshake: draw_req/pass_req are single-cycle pulses sampled only in IDLE (busy=0);
  // pulses arriving while busy=1 are dropped. card_valid pulses for one cycle per dealt card.

  localparam int DECK_SIZE = 1 << CARD_W;
  localparam logic [CARD_W:0] DECK_FULL = DECK_SIZE[CARD_W:0];
  localparam logic [PID_W-1:0] LAST_PLAYER = PID_W'(NUM_PLAYERS - 1);

`ifdef AUTO_RESHUFFLE_EN
  localparam bit RESHUFFLE_EN = 1'b1;
`else
  localparam bit RESHUFFLE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DEAL   = 2'd2
  } state_t;

  state_t                 state;
  logic [15:0]            lfsr;
  logic                   lfsr_fb;
  logic [DECK_SIZE-1:0]   used;
  logic [CARD_W-1:0]      probe;
  logic [PID_W-1:0]       next_player;

  // Fibonacci taps 16,14,13,11 in right-shift form.
  assign lfsr_fb     = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign next_player = (cur_player == LAST_PLAYER) ? '0 : cur_player + PID_W'(1);

  assign deck_empty  = (cards_dealt == DECK_FULL);
  assign card_color  = card_id[CARD_W-1:CARD_W-2];
  assign card_number = card_id[CARD_W-3:0];
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      used        <= '0;
      probe       <= '0;
      card_id     <= '0;
      card_player <= '0;
      cur_player  <= '0;
      cards_dealt <= '0;
      card_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      lfsr       <= {lfsr_fb, lfsr[15:1]};
      card_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A draw request takes priority; a simultaneous pass is discarded.
          if (draw_req) begin
            if (!deck_empty || RESHUFFLE_EN) begin
              if (deck_empty) begin
                used        <= '0;
                cards_dealt <= '0;
              end
              probe <= lfsr[CARD_W-1:0];
              busy  <= 1'b1;
              state <= SEARCH;
            end
          end else if (pass_req) begin
            cur_player <= next_player;
          end
        end
        SEARCH: begin
          // Linear probe from the random start; a free card always exists here.
          if (!used[probe]) begin
            card_id     <= probe;
            card_player <= cur_player;
            card_valid  <= 1'b1;
            state       <= DEAL;
          end else begin
            probe <= probe + CARD_W'(1);
          end
        end
        DEAL: begin
          used[card_id] <= 1'b1;
          cards_dealt   <= cards_dealt + (CARD_W+1)'(1);
          cur_player    <= next_player;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
